// File: rtl/chacha_pkg.sv
// Shared types, constants and word-index helpers for the byte-serial ChaCha engine.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef logic [15:0][31:0] state_t;

    localparam word_t SIGMA0 = 32'h61707865;
    localparam word_t SIGMA1 = 32'h3320646e;
    localparam word_t SIGMA2 = 32'h79622d32;
    localparam word_t SIGMA3 = 32'h6b206574;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } fsm_state_t;

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Column qr uses words qr, qr+4, qr+8, qr+12.
    function automatic logic [3:0] col_word(input logic [1:0] qr, input logic [1:0] k);
        return {k, qr};
    endfunction

    // Diagonal qr walks one lane right per row, wrapping inside the row.
    function automatic logic [3:0] diag_word(input logic [1:0] qr, input logic [1:0] k);
        logic [1:0] lane;
        lane = qr + k;
        return {k, lane};
    endfunction

    function automatic logic [3:0] qr_word(input logic odd, input logic [1:0] qr,
                                           input logic [1:0] k);
        return odd ? diag_word(qr, k) : col_word(qr, k);
    endfunction

endpackage

// File: rtl/chacha_block_serial_quarter_round.sv
// Combinational ChaCha quarter-round: add / xor / rotate on one word quadruple.
module chacha_quarter_round
    import chacha_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_new,
    output word_t b_new,
    output word_t c_new,
    output word_t d_new
);

    word_t a1, b1, c1, d1;

    always_comb begin
        a1    = a + b;
        d1    = rotl(d ^ a1, 16);
        c1    = c + d1;
        b1    = rotl(b ^ c1, 12);
        a_new = a1 + b1;
        d_new = rotl(d1 ^ a_new, 8);
        c_new = c1 + d_new;
        b_new = rotl(b1 ^ c_new, 7);
    end

endmodule

// File: rtl/chacha_block_serial.sv
// Byte-serial ChaCha block engine: load 64 bytes, run ROUNDS rounds at one
// quarter-round per clock, optionally feed forward, stream 64 bytes out.
module chacha_block_serial
    import chacha_pkg::*;
#(
    parameter int ROUNDS      = 20,
    parameter bit FEEDFORWARD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    if (ROUNDS < 2 || ROUNDS > 20 || (ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("chacha_block_serial: ROUNDS must be even and within 2..20");
    end

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    fsm_state_t fsm, fsm_next;
    logic [5:0] byte_cnt;
    logic [1:0] qr_idx;
    logic [4:0] round_cnt;
    state_t     st;
    state_t     saved;

    logic load_en, out_en, last_qr;
    logic [3:0] ia, ib, ic, id;
    word_t qa_new, qb_new, qc_new, qd_new;

    assign last_qr = (qr_idx == 2'd3) && (round_cnt == LAST_ROUND);

    // Odd rounds are diagonal rounds.
    assign ia = qr_word(round_cnt[0], qr_idx, 2'd0);
    assign ib = qr_word(round_cnt[0], qr_idx, 2'd1);
    assign ic = qr_word(round_cnt[0], qr_idx, 2'd2);
    assign id = qr_word(round_cnt[0], qr_idx, 2'd3);

    chacha_quarter_round u_qr (
        .a     (st[ia]),
        .b     (st[ib]),
        .c     (st[ic]),
        .d     (st[id]),
        .a_new (qa_new),
        .b_new (qb_new),
        .c_new (qc_new),
        .d_new (qd_new)
    );

    // Handshakes: a byte moves on a rising edge where valid && ready.
    // in_ready is high only in LOAD, out_valid only in OUT.
    always_comb begin
        fsm_next  = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load_en   = 1'b0;
        out_en    = 1'b0;
        out_data  = 8'h00;
        case (fsm)
            LOAD: begin
                in_ready = 1'b1;
                load_en  = in_valid;
                if (in_valid && byte_cnt == 6'd63) fsm_next = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (last_qr) fsm_next = FINAL;
            end
            FINAL: begin
                busy     = 1'b1;
                fsm_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_en    = out_ready;
                out_data  = st[byte_cnt[5:2]][{byte_cnt[1:0], 3'b000} +: 8];
                if (out_ready && byte_cnt == 6'd63) fsm_next = LOAD;
            end
            default: fsm_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= LOAD;
            byte_cnt  <= 6'd0;
            qr_idx    <= 2'd0;
            round_cnt <= 5'd0;
        end else begin
            fsm <= fsm_next;
            if (load_en || out_en) byte_cnt <= byte_cnt + 6'd1;
            if (fsm == ROUND) begin
                qr_idx <= qr_idx + 2'd1;
                if (qr_idx == 2'd3) round_cnt <= last_qr ? 5'd0 : round_cnt + 5'd1;
            end
        end
    end

    // State words are not reset; the FSM guarantees they are reloaded before use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_en) begin
                st[byte_cnt[5:2]][{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
                if (FEEDFORWARD)
                    saved[byte_cnt[5:2]][{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
            end
            if (fsm == ROUND) begin
                st[ia] <= qa_new;
                st[ib] <= qb_new;
                st[ic] <= qc_new;
                st[id] <= qd_new;
            end
            if (fsm == FINAL && FEEDFORWARD) begin
                for (int i = 0; i < 16; i++) st[i] <= st[i] + saved[i];
            end
        end
    end

endmodule

// File: tb/tb_chacha_block_serial.sv
// Directed bench: quarter-round vectors, full ChaCha20 block, backpressure,
// mid-round reset, input gating and an 8-round raw-permutation instance.
module tb_chacha_block_serial;
    import chacha_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, out_ready, sel;

    logic       in_ready_a, out_valid_a, busy_a;
    logic [7:0] out_data_a;
    logic       in_ready_b, out_valid_b, busy_b;
    logic [7:0] out_data_b;
    logic       in_valid_a, in_valid_b;

    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;

    chacha_block_serial #(.ROUNDS(20), .FEEDFORWARD(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .busy(busy_a)
    );

    chacha_block_serial #(.ROUNDS(8), .FEEDFORWARD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .busy(busy_b)
    );

    logic       cur_in_ready, cur_out_valid, cur_busy;
    logic [7:0] cur_out_data;
    assign cur_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign cur_out_valid = sel ? out_valid_b : out_valid_a;
    assign cur_busy      = sel ? busy_b      : busy_a;
    assign cur_out_data  = sel ? out_data_b  : out_data_a;

    word_t qa, qb, qc, qd, qa_n, qb_n, qc_n, qd_n;
    chacha_quarter_round u_qr (
        .a(qa), .b(qb), .c(qc), .d(qd),
        .a_new(qa_n), .b_new(qb_n), .c_new(qc_n), .d_new(qd_n)
    );

    typedef struct {
        word_t a, b, c, d;
        word_t ea, eb, ec, ed;
    } qr_vec_t;

    qr_vec_t    qr_tab[3];
    word_t      vec_words[16];
    word_t      exp_words[16];
    logic [7:0] in_bytes[64];

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic fill_bytes(input bit zero);
        for (int k = 0; k < 64; k++)
            in_bytes[k] = zero ? 8'h00 : vec_words[k / 4][8 * (k % 4) +: 8];
    endtask

    task automatic load_exp(input bit zero);
        exp_q.delete();
        for (int k = 0; k < 64; k++)
            exp_q.push_back(zero ? 8'h00 : exp_words[k / 4][8 * (k % 4) +: 8]);
    endtask

    task automatic send_block(input bit junk, output int acc);
        for (int k = 0; k < 64; k++) begin
            int t;
            t = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = in_bytes[k];
            while (!cur_in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("load_ready_timeout", 32'(cur_in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = junk;
        end
        acc = cyc;
    endtask

    task automatic wait_out(input int acc, input int exp_lat, input bit junk, input string name);
        int t;
        t = 0;
        chk({name, "_busy"}, 32'(cur_busy), 32'd1);
        while (t < 500) begin
            @(negedge clk);
            if (junk) in_data = 8'($urandom);
            if (cur_out_valid) break;
            t++;
        end
        chk({name, "_latency"}, 32'(cyc - acc), 32'(exp_lat));
    endtask

    // Starts at a negedge with out_valid high; ends at the negedge after the last transfer.
    task automatic recv_block(input bit bp, input bit junk, input string name);
        int n, t, stall_left, stable_bad;
        bit did_stall, prev_stall, saw_ready;
        logic [7:0] held, exp_b;
        n = 0; t = 0; stall_left = 0; stable_bad = 0;
        did_stall = 0; prev_stall = 0; saw_ready = 0; held = 8'h00;
        while (n < 64 && t < 3000) begin
            if (junk) in_data = 8'($urandom);
            if (bp) begin
                if (n == 20 && !did_stall) begin
                    stall_left = 10;
                    did_stall  = 1;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                out_ready = 1'b1;
            end
            if (cur_in_ready) saw_ready = 1;
            if (prev_stall && cur_out_data !== held) stable_bad++;
            if (cur_out_valid && out_ready) begin
                exp_b = exp_q.pop_front();
                chk($sformatf("%s_byte%0d", name, n), 32'(cur_out_data), 32'(exp_b));
                n++;
                if (n == 64 && junk) in_valid = 1'b0;
            end
            prev_stall = cur_out_valid && !out_ready;
            held       = cur_out_data;
            @(negedge clk);
            t++;
        end
        out_ready = 1'b1;
        chk({name, "_bytes_done"}, 32'(n), 32'd64);
        chk({name, "_stable"}, 32'(stable_bad), 32'd0);
        chk({name, "_in_ready_in_out"}, 32'(saw_ready), 32'd0);
        chk({name, "_back_in_ready"}, 32'(cur_in_ready), 32'd1);
        chk({name, "_back_out_valid"}, 32'(cur_out_valid), 32'd0);
    endtask

    task automatic run_block(input bit zero, input bit bp, input bit junk,
                             input int exp_lat, input string name);
        int acc;
        fill_bytes(zero);
        load_exp(zero);
        send_block(junk, acc);
        wait_out(acc, exp_lat, junk, name);
        recv_block(bp, junk, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        bit seen_valid;

        qr_tab[0] = '{32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567,
                      32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
        qr_tab[1] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        qr_tab[2] = '{32'h0, 32'h0, 32'h0, 32'h1,
                      32'h10000000, 32'h80800808, 32'h01010010, 32'h01000010};

        vec_words = '{SIGMA0, SIGMA1, SIGMA2, SIGMA3,
                      32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                      32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        exp_words = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                      32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                      32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                      32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready_a), 32'd1);
        chk("reset_out_valid", 32'(out_valid_a), 32'd0);
        chk("reset_out_data", 32'(out_data_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_b_in_ready", 32'(in_ready_b), 32'd1);

        for (int i = 0; i < 3; i++) begin
            qa = qr_tab[i].a; qb = qr_tab[i].b; qc = qr_tab[i].c; qd = qr_tab[i].d;
            #1;
            chk($sformatf("qr%0d_a", i), qa_n, qr_tab[i].ea);
            chk($sformatf("qr%0d_b", i), qb_n, qr_tab[i].eb);
            chk($sformatf("qr%0d_c", i), qc_n, qr_tab[i].ec);
            chk($sformatf("qr%0d_d", i), qd_n, qr_tab[i].ed);
        end

        run_block(1'b0, 1'b0, 1'b0, 81, "chacha20");
        run_block(1'b0, 1'b1, 1'b0, 81, "backpressure");

        // Abandon a block at round 7, then confirm nothing leaks out.
        fill_bytes(1'b0);
        send_block(1'b0, acc);
        repeat (29) @(posedge clk);
        #1;
        chk("midreset_busy_before", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 32'(out_valid_a), 32'd0);
        chk("midreset_in_ready", 32'(in_ready_a), 32'd1);
        chk("midreset_busy", 32'(busy_a), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (out_valid_a) seen_valid = 1;
        end
        chk("midreset_no_partial_output", 32'(seen_valid), 32'd0);
        run_block(1'b0, 1'b0, 1'b0, 81, "after_reset");

        run_block(1'b0, 1'b1, 1'b1, 81, "gated");
        run_block(1'b0, 1'b0, 1'b0, 81, "post_gated");

        sel = 1'b1;
        run_block(1'b1, 1'b0, 1'b0, 33, "raw8_zero");
        sel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
